cntr_preset_seq: RTL
====================

Name: cntr_preset_seq

Overview:
Upstream sequencer that drives the d/ld load interface of the 4-bit loadable binary counter.
- Host pushes {preset, terminal} pairs into a small FIFO.
- For each pair, the block loads the preset, lets the counter run, and watches the counter's q.
- When q reaches the terminal value, it signals done and loads the next preset or parks the counter.
- Turns the free-running counter into a programmable multi-segment timer.

Parameters:
WIDTH, 4, counter/data width; must match the counter.
DEPTH, 4, FIFO entries; power of 2, at least 2.
AW, 2, log2(DEPTH).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high; dominates all other inputs
in_valid  in  1  host offers a pair
in_ready  out  1  FIFO can accept; equals not full
in_preset  in  WIDTH  start value for the segment
in_term  in  WIDTH  terminal value for the segment
q  in  WIDTH  counter output, fed back
ld  out  1  to counter ld, registered
d  out  WIDTH  to counter d, registered
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse per completed segment, registered
level  out  AW+1  FIFO occupancy, 0..DEPTH

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, ld=1, d=0, done=0, FIFO empty (level=0, in_ready=1), term_r=0. The counter is held at 0.
- Push: occurs on the edge where in_valid && in_ready. When full, in_ready=0, even if a pop happens in the same cycle; there is no bypass. Push and pop in the same cycle leave level unchanged.
- FSM has three states, encoded IDLE=00, LOAD=01, RUN=10:
  - IDLE: ld held 1, d=term_r, so the counter parks at term_r. If the FIFO is not empty: pop, d<=preset, term_r<=term, go to LOAD.
  - LOAD: ld=1 with d=preset during this cycle, so the counter loads at the end of it. Set ld<=0, go to RUN.
  - RUN: ld=0, counter increments. If q==term_r: done<=1, ld<=1.
    - FIFO not empty: pop, d<=next preset, term_r<=next term, go to LOAD.
    - FIFO empty: d<=term_r, go to IDLE.
    - Otherwise stay in RUN. done is 0 in all other cycles.
- Latency:
  - Push at edge E0.
  - Pop at E1; this requires IDLE and an empty FIFO before the push.
  - LOAD is the cycle after E1.
  - q=preset is visible after E2.
- Segment sequence on q: preset, preset+1 .. term, then one overshoot cycle at term+1 (mod 2^WIDTH) with done=1. After that, q=next preset, or q=term parked.
- Wrap-around: the counter wraps 15->0. Segment length is ((term-preset) mod 16)+1 cycles.
- Boundary cases:
  - preset==term: done follows after exactly one RUN cycle.
  - Back-to-back segments have no gap beyond the overshoot cycle.
- Arithmetic: only equality compare of q against term_r; no adders in this block. FIFO pointers are AW bits and wrap naturally; level is AW+1 bits.
- Reset mid-operation: the next cycle shows reset values. The FIFO contents are discarded and any in-flight segment produces no done.

Decomposition:
- Shared package/include cntr_pkg holds:
  - the WIDTH default;
  - state encodings IDLE, LOAD, RUN;
  - the pair-packing localparams: preset in [2*WIDTH-1:WIDTH], term in [WIDTH-1:0].
- Sub-module preset_fifo: synchronous FIFO of 2*WIDTH-bit entries.
  - Ports: clk, rst, push, pop, wdata, rdata, full, empty, level.
  - rdata is the head entry, visible combinationally.
- Top level is FSM plus registers only. Bench integrates it with the counter, connecting d, ld and q.

Test Plan:
- Reset: hold rst 2 cycles -> ld=1, d=0, busy=0, done=0, in_ready=1, level=0; counter q=0 and stays 0.
- Single segment: push (preset=3, term=6) -> q = 0,0,3,4,5,6,7, then 6 held. done=1 only in the q=7 cycle; busy high from LOAD through the q=6 cycle.
- Wrap: push (14, 1) -> q = 14,15,0,1,2, then 1 held. done=1 when q=2.
- Back-to-back: push (2, 4) then (9, 9) -> q = 2,3,4,5,9,10, then 9 held. done pulses at q=5 and q=10; no idle cycles between segments.
- Full FIFO: with a long segment (0, 15) running, push 5 pairs -> 4 accepted, level=4, in_ready=0 while full. The 5th is accepted only after a pop frees an entry.
- Reset mid-RUN: rst asserted while q=5 of segment (3, 9), with 2 entries queued -> next cycle ld=1, d=0, level=0, done=0, state IDLE. No further done pulses.

Source files
------------

// File: rtl/cntr_pkg.sv
// Shared definitions for the preset sequencer:
// widths, FSM encodings and FIFO pair packing.
package cntr_pkg;

  localparam int CNTR_WIDTH = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_e;

  // pair word: preset in upper half, term in lower half
  localparam int PRE_LSB  = CNTR_WIDTH;
  localparam int TERM_LSB = 0;

endpackage

// File: rtl/cntr_preset_seq_if.sv
// Host push channel of the preset sequencer:
// a valid/ready offer of one {preset, term} pair.
interface cntr_preset_seq_if #(
  parameter int WIDTH = cntr_pkg::CNTR_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_preset;
  logic [WIDTH-1:0] in_term;

  modport master (
    output in_valid,
    output in_preset,
    output in_term,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_preset,
    input  in_term,
    output in_ready
  );

endinterface

// File: rtl/preset_fifo.sv
// Small synchronous FIFO holding pending segments;
// the head entry is visible combinationally.
module preset_fifo
  import cntr_pkg::*;
#(
  parameter int DW    = 2 * CNTR_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rp_q];
  assign level   = cnt_q;

  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wp_q] <= wdata;
    end
  end

  // pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wp_q <= wp_q + 1'b1;
      end
      if (do_pop) begin
        rp_q <= rp_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cntr_preset_seq.sv
// Sequencer driving a loadable counter through
// queued {preset, terminal} segments.
module cntr_preset_seq
  import cntr_pkg::*;
#(
  parameter int WIDTH = CNTR_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic             clk,
  input  logic             rst,
  cntr_preset_seq_if.slave in_if,
  input  logic [WIDTH-1:0] q,
  output logic             ld,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      level
);

  state_e           state_q;
  logic [WIDTH-1:0] term_q;
  logic [WIDTH-1:0] d_q;
  logic             ld_q;
  logic             done_q;

  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_pre;
  logic [WIDTH-1:0]   head_term;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               hit;

  assign in_if.in_ready = !full;
  assign push = in_if.in_valid && !full;
  assign hit  = (q == term_q);
  assign pop  = !empty &&
                ((state_q == IDLE) ||
                 ((state_q == RUN) && hit));

  assign head_pre  = head[PRE_LSB +: WIDTH];
  assign head_term = head[TERM_LSB +: WIDTH];

  assign ld   = ld_q;
  assign d    = d_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

  preset_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_if.in_preset, in_if.in_term}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // segment FSM with registered counter controls
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      term_q  <= '0;
      d_q     <= '0;
      ld_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            d_q     <= head_pre;
            term_q  <= head_term;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          ld_q    <= 1'b0;
          state_q <= RUN;
        end
        RUN: begin
          if (hit) begin
            done_q <= 1'b1;
            ld_q   <= 1'b1;
            if (pop) begin
              d_q     <= head_pre;
              term_q  <= head_term;
              state_q <= LOAD;
            end else begin
              d_q     <= term_q;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          ld_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
